acc_responder: RTL

ACC_RESPONDER -- requirements
Module: acc_responder

---
 rtl/acc_pkg.sv | 6 +
 rtl/acc_responder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/acc_pkg.sv
// Shared constants for the accelerator request fabric.
package acc_pkg;

    localparam int unsigned AccAddrWidth = 8;

endpackage

// File: rtl/acc_responder.sv
// Accelerator request responder: forwards address hits to a backend, answers misses with an
// error, and returns every response in acceptance order through a registered output stage.
module acc_responder #(
    parameter int unsigned             AccAddrWidth = acc_pkg::AccAddrWidth,
    parameter int unsigned             DataWidth    = 32,
    parameter int unsigned             IdWidth      = 6,
    parameter int unsigned             Depth        = 4,
    parameter logic [AccAddrWidth-1:0] AccAddr      = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       q_valid_i,
    output logic                       q_ready_o,
    input  logic [AccAddrWidth-1:0]    q_addr_i,
    input  logic [IdWidth-1:0]         q_id_i,
    input  logic [31:0]                q_op_i,
    input  logic [DataWidth-1:0]       q_arg_a_i,
    input  logic [DataWidth-1:0]       q_arg_b_i,
    output logic                       p_valid_o,
    input  logic                       p_ready_i,
    output logic [IdWidth-1:0]         p_id_o,
    output logic [DataWidth-1:0]       p_data_o,
    output logic                       p_error_o,
    output logic                       be_valid_o,
    input  logic                       be_ready_i,
    output logic [31:0]                be_op_o,
    output logic [DataWidth-1:0]       be_arg_a_o,
    output logic [DataWidth-1:0]       be_arg_b_o,
    input  logic                       be_rvalid_i,
    input  logic [DataWidth-1:0]       be_result_i,
    input  logic                       be_error_i,
    output logic [$clog2(Depth+1)-1:0] outstanding_o
);

    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam int unsigned PtrWidth = $clog2(Depth);

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + PtrWidth'(1);
    endfunction

    logic [IdWidth-1:0]   tag_id_q   [Depth];
    logic [IdWidth-1:0]   tag_id_d   [Depth];
    logic [Depth-1:0]     tag_miss_q, tag_miss_d;
    logic [PtrWidth-1:0]  tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [CntWidth-1:0]  tag_cnt_q, tag_cnt_d;

    logic [DataWidth-1:0] res_data_q [Depth];
    logic [DataWidth-1:0] res_data_d [Depth];
    logic [Depth-1:0]     res_err_q, res_err_d;
    logic [PtrWidth-1:0]  res_wr_q, res_wr_d, res_rd_q, res_rd_d;
    logic [CntWidth-1:0]  res_cnt_q, res_cnt_d;

    logic [CntWidth-1:0]  outstanding_q, outstanding_d;
    logic [CntWidth-1:0]  hit_pend_q, hit_pend_d;

    logic                 p_valid_q, p_valid_d, p_error_q, p_error_d;
    logic [IdWidth-1:0]   p_id_q, p_id_d;
    logic [DataWidth-1:0] p_data_q, p_data_d;

    logic hit, full, accept, tag_empty, res_empty, res_full, res_in;
    logic head_valid, head_miss, head_rdy, load;
    logic tag_push, tag_pop, res_take, res_push, res_pop, head_err;
    logic [IdWidth-1:0]   head_id;
    logic [DataWidth-1:0] head_data;

    // Capacity is bounded by everything in flight, including the response held in the output stage.
    assign hit        = (q_addr_i == AccAddr);
    assign full       = (outstanding_q == CntWidth'(Depth));
    assign q_ready_o  = ~full & (~hit | be_ready_i);
    assign be_valid_o = q_valid_i & hit & ~full;
    assign be_op_o    = q_op_i;
    assign be_arg_a_o = q_arg_a_i;
    assign be_arg_b_o = q_arg_b_i;
    assign accept     = q_valid_i & q_ready_o;

    assign tag_empty  = (tag_cnt_q == '0);
    assign res_empty  = (res_cnt_q == '0);
    assign res_full   = (res_cnt_q == CntWidth'(Depth));
    // Results with no hit awaiting them (e.g. issued before a reset) are dropped.
    assign res_in     = be_rvalid_i & ~res_full & ((hit_pend_q != '0) | (accept & hit));

    // Empty queues are bypassed so a fresh request or result can load the output stage directly.
    assign head_valid = ~tag_empty | accept;
    assign head_id    = tag_empty ? q_id_i : tag_id_q[tag_rd_q];
    assign head_miss  = tag_empty ? ~hit : tag_miss_q[tag_rd_q];
    assign head_data  = res_empty ? be_result_i : res_data_q[res_rd_q];
    assign head_err   = res_empty ? be_error_i : res_err_q[res_rd_q];
    assign head_rdy   = head_valid & (head_miss | ~res_empty | res_in);
    assign load       = head_rdy & (~p_valid_q | p_ready_i);

    assign tag_push   = accept & ~(tag_empty & load);
    assign tag_pop    = load & ~tag_empty;
    assign res_take   = load & ~head_miss;
    assign res_push   = res_in & ~(res_empty & res_take);
    assign res_pop    = res_take & ~res_empty;

    always_comb begin
        tag_id_d   = tag_id_q;
        tag_miss_d = tag_miss_q;
        tag_wr_d   = tag_wr_q;
        tag_rd_d   = tag_rd_q;
        res_data_d = res_data_q;
        res_err_d  = res_err_q;
        res_wr_d   = res_wr_q;
        res_rd_d   = res_rd_q;
        if (tag_push) begin
            tag_id_d[tag_wr_q]   = q_id_i;
            tag_miss_d[tag_wr_q] = ~hit;
            tag_wr_d             = ptr_inc(tag_wr_q);
        end
        if (tag_pop) tag_rd_d = ptr_inc(tag_rd_q);
        if (res_push) begin
            res_data_d[res_wr_q] = be_result_i;
            res_err_d[res_wr_q]  = be_error_i;
            res_wr_d             = ptr_inc(res_wr_q);
        end
        if (res_pop) res_rd_d = ptr_inc(res_rd_q);
        tag_cnt_d     = tag_cnt_q + CntWidth'(tag_push) - CntWidth'(tag_pop);
        res_cnt_d     = res_cnt_q + CntWidth'(res_push) - CntWidth'(res_pop);
        outstanding_d = outstanding_q + CntWidth'(accept) - CntWidth'(p_valid_q & p_ready_i);
        hit_pend_d    = hit_pend_q + CntWidth'(accept & hit) - CntWidth'(res_in);
    end

    // Output stage: load the next in-order response, otherwise hold or retire.
    always_comb begin
        p_valid_d = p_valid_q;
        p_id_d    = p_id_q;
        p_data_d  = p_data_q;
        p_error_d = p_error_q;
        if (load) begin
            p_valid_d = 1'b1;
            p_id_d    = head_id;
            p_data_d  = head_miss ? '0 : head_data;
            p_error_d = head_miss | head_err;
        end else if (p_ready_i) begin
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            tag_miss_q    <= '0;
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            tag_cnt_q     <= '0;
            res_err_q     <= '0;
            res_wr_q      <= '0;
            res_rd_q      <= '0;
            res_cnt_q     <= '0;
            outstanding_q <= '0;
            hit_pend_q    <= '0;
            p_valid_q     <= 1'b0;
            p_id_q        <= '0;
            p_data_q      <= '0;
            p_error_q     <= 1'b0;
        end else begin
            tag_miss_q    <= tag_miss_d;
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            tag_cnt_q     <= tag_cnt_d;
            res_err_q     <= res_err_d;
            res_wr_q      <= res_wr_d;
            res_rd_q      <= res_rd_d;
            res_cnt_q     <= res_cnt_d;
            outstanding_q <= outstanding_d;
            hit_pend_q    <= hit_pend_d;
            p_valid_q     <= p_valid_d;
            p_id_q        <= p_id_d;
            p_data_q      <= p_data_d;
            p_error_q     <= p_error_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the counters.
    always_ff @(posedge clk_i) begin
        tag_id_q   <= tag_id_d;
        res_data_q <= res_data_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && be_rvalid_i) begin
            assert (!res_full && ((hit_pend_q != '0) || (accept && hit)))
                else $error("acc_responder: backend result with no room or no pending hit");
        end
    end

    assign p_valid_o     = p_valid_q;
    assign p_id_o        = p_id_q;
    assign p_data_o      = p_data_q;
    assign p_error_o     = p_error_q;
    assign outstanding_o = outstanding_q;

endmodule
